// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, NORM/ISR fetch-source selection and
// the IF/ID pipeline register.
// Optional feature macro: COMPRESSED_FETCH_EN. When it is defined, 16-bit
// instructions (inst[1:0] != 2'b11) advance the PC by 2 and halfword-aligned
// PCs are allowed. When it is undefined, every fetch advances the PC by 4 and
// the PC stays word aligned.
`ifndef PC_ADDR_BITS
`define PC_ADDR_BITS 12
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module if_stage #(
   parameter int                     PC_ADDR_BITS = `PC_ADDR_BITS,
   parameter int                     WORD_WIDTH   = `WORD_WIDTH,
   parameter logic [WORD_WIDTH-1:0]  NOP_INST     = WORD_WIDTH'(32'h00000013)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic                      redirect,
   input  logic [PC_ADDR_BITS-1:0]   redirect_pc,
   input  logic                      int_req,
   input  logic                      isr_ret,
   input  logic [WORD_WIDTH-1:0]     inst,
   output logic [PC_ADDR_BITS-1:0]   pc,
   output logic                      sel_isr,
   output logic                      int_ack,
   output logic [WORD_WIDTH-1:0]     if_id_inst,
   output logic [PC_ADDR_BITS-1:0]   if_id_pc,
   output logic                      if_id_valid,
   output logic                      if_id_is_c
);

   typedef enum logic {NORM = 1'b0, ISR = 1'b1} state_t;

   state_t                   state_reg;
   state_t                   state_next;
   logic                     take_int;
   logic                     take_ret;

   logic [PC_ADDR_BITS-1:0]  pc_reg;
   logic [PC_ADDR_BITS-1:0]  epc_reg;
   logic [WORD_WIDTH-1:0]    if_id_inst_reg;
   logic [PC_ADDR_BITS-1:0]  if_id_pc_reg;
   logic                     if_id_valid_reg;
   logic                     if_id_is_c_reg;

   logic                     inst_is_c;
   logic [PC_ADDR_BITS-1:0]  redirect_aligned;
   logic [PC_ADDR_BITS-1:0]  pc_seq;

`ifdef COMPRESSED_FETCH_EN
   // Halfword granularity: low two bits of the opcode tell 16- from 32-bit.
   assign inst_is_c        = (inst[1:0] != 2'b11);
   assign redirect_aligned = {redirect_pc[PC_ADDR_BITS-1:1], 1'b0};
   logic unused_redirect_bits;
   assign unused_redirect_bits = redirect_pc[0];
`else
   // Word granularity only: every instruction is treated as 32-bit.
   assign inst_is_c        = 1'b0;
   assign redirect_aligned = {redirect_pc[PC_ADDR_BITS-1:2], 2'b00};
   logic unused_redirect_bits;
   assign unused_redirect_bits = ^redirect_pc[1:0];
`endif

   // Sequential fetch address; natural wrap at 2^PC_ADDR_BITS.
   assign pc_seq = pc_reg + (inst_is_c ? PC_ADDR_BITS'(2) : PC_ADDR_BITS'(4));

   // State register: reset always lands back in NORM.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= NORM;
      else     state_reg <= state_next;
   end

   // Next-state: redirect beats interrupt entry, which beats ISR return.
   always_comb begin
      state_next = state_reg;
      take_int   = 1'b0;
      take_ret   = 1'b0;
      if (!redirect) begin
         if (state_reg == NORM && int_req && !stall) begin
            take_int   = 1'b1;
            state_next = ISR;
         end else if (state_reg == ISR && isr_ret) begin
            take_ret   = 1'b1;
            state_next = NORM;
         end
      end
   end

   // FSM outputs: ROM select follows the registered state, ack is a pulse.
   always_comb begin
      sel_isr = (state_reg == ISR);
      int_ack = take_int && !rst;
   end

   // PC, saved return PC and IF/ID register, in the same priority order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg          <= '0;
         epc_reg         <= '0;
         if_id_inst_reg  <= NOP_INST;
         if_id_pc_reg    <= '0;
         if_id_valid_reg <= 1'b0;
         if_id_is_c_reg  <= 1'b0;
      end else if (redirect) begin
         pc_reg          <= redirect_aligned;
         if_id_inst_reg  <= NOP_INST;
         if_id_valid_reg <= 1'b0;
         if_id_is_c_reg  <= 1'b0;
      end else if (take_int) begin
         epc_reg         <= pc_reg;
         pc_reg          <= '0;
         if_id_inst_reg  <= NOP_INST;
         if_id_valid_reg <= 1'b0;
         if_id_is_c_reg  <= 1'b0;
      end else if (take_ret) begin
         pc_reg          <= epc_reg;
         if_id_inst_reg  <= NOP_INST;
         if_id_valid_reg <= 1'b0;
         if_id_is_c_reg  <= 1'b0;
      end else if (!stall) begin
         pc_reg          <= pc_seq;
         if_id_inst_reg  <= inst;
         if_id_pc_reg    <= pc_reg;
         if_id_valid_reg <= 1'b1;
         if_id_is_c_reg  <= inst_is_c;
      end
   end

   assign pc          = pc_reg;
   assign if_id_inst  = if_id_inst_reg;
   assign if_id_pc    = if_id_pc_reg;
   assign if_id_valid = if_id_valid_reg;
   assign if_id_is_c  = if_id_is_c_reg;

endmodule

// File: tb/tb_if_stage.sv
// Randomized + directed bench for if_stage against a behavioural model.
`timescale 1ns/1ps
module tb_if_stage;
   localparam int          AW  = 12;
   localparam int          WW  = 32;
   localparam logic [31:0] NOP = 32'h00000013;
`ifdef COMPRESSED_FETCH_EN
   localparam bit CMP = 1'b1;
`else
   localparam bit CMP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0, stall = 1'b0, redirect = 1'b0, int_req = 1'b0, isr_ret = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic [WW-1:0] inst = '0;
   logic [AW-1:0] pc, if_id_pc;
   logic          sel_isr, int_ack, if_id_valid, if_id_is_c;
   logic [WW-1:0] if_id_inst;

   always #5 clk = ~clk;

   if_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .int_req(int_req), .isr_ret(isr_ret),
      .inst(inst), .pc(pc), .sel_isr(sel_isr), .int_ack(int_ack),
      .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
      .if_id_valid(if_id_valid), .if_id_is_c(if_id_is_c)
   );

   // Behavioural model state
   int          m_pc = 0, m_epc = 0, m_ipc = 0;
   bit          m_isr = 0, m_valid = 0, m_isc = 0;
   logic [31:0] m_inst = NOP;

   int   n_vec = 0, n_bad = 0;
   logic ack_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is16(input logic [31:0] i);
      return CMP && (i[1:0] != 2'b11);
   endfunction

   // One clock: drive, check combinational ack, advance model, compare all.
   task automatic step(input bit r, input bit s, input bit rd, input int rpc,
                       input bit ir, input bit ret, input logic [31:0] ins);
      bit exp_ack;
      rst = r; stall = s; redirect = rd; redirect_pc = rpc[AW-1:0];
      int_req = ir; isr_ret = ret; inst = ins;
      exp_ack = !r && !m_isr && ir && !s && !rd;
      #1;
      ack_seen = int_ack;
      chk("int_ack", {31'b0, int_ack}, {31'b0, exp_ack});
      @(posedge clk);
      if (r) begin
         m_pc = 0; m_isr = 0; m_epc = 0; m_valid = 0; m_inst = NOP; m_ipc = 0; m_isc = 0;
      end else if (rd) begin
         m_pc = CMP ? (rpc % 4096) / 2 * 2 : (rpc % 4096) / 4 * 4;
         m_valid = 0; m_inst = NOP;
      end else if (exp_ack) begin
         m_epc = m_pc; m_pc = 0; m_isr = 1; m_valid = 0; m_inst = NOP;
      end else if (m_isr && ret) begin
         m_pc = m_epc; m_isr = 0; m_valid = 0; m_inst = NOP;
      end else if (!s) begin
         m_ipc = m_pc; m_inst = ins; m_valid = 1; m_isc = is16(ins);
         m_pc = (m_pc + (is16(ins) ? 2 : 4)) % (1 << AW);
      end
      #1;
      chk("pc", 32'(pc), 32'(m_pc));
      chk("sel_isr", {31'b0, sel_isr}, {31'b0, m_isr});
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("if_id_inst", if_id_inst, m_inst);
      if (m_valid) begin
         chk("if_id_pc", 32'(if_id_pc), 32'(m_ipc));
         chk("if_id_is_c", {31'b0, if_id_is_c}, {31'b0, m_isc});
      end
   endtask

   localparam logic [31:0] ADDI = 32'h00500093;
   localparam logic [31:0] CLI  = 32'h00004505;

   initial begin
      logic [31:0] ri;
      // Reset, with int_req high: no ack during reset
      step(1, 0, 0, 0, 1, 0, ADDI);
      chk("rst_ack", {31'b0, ack_seen}, 32'd0);
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_inst", if_id_inst, NOP);
      chk("rst_ifpc", 32'(if_id_pc), 32'h0);
      chk("rst_isc", {31'b0, if_id_is_c}, 32'd0);
      // Three sequential 32-bit fetches
      step(0, 0, 0, 0, 0, 0, ADDI);
      chk("seq1_pc", 32'(pc), 32'h4);
      chk("seq1_ifpc", 32'(if_id_pc), 32'h0);
      chk("seq1_valid", {31'b0, if_id_valid}, 32'd1);
      step(0, 0, 0, 0, 0, 0, ADDI);
      chk("seq2_pc", 32'(pc), 32'h8);
      chk("seq2_ifpc", 32'(if_id_pc), 32'h4);
      step(0, 0, 0, 0, 0, 0, ADDI);
      // Compressed instruction at 0x010
      step(0, 0, 1, 'h010, 0, 0, ADDI);
      chk("redir_pc", 32'(pc), 32'h010);
      step(0, 0, 0, 0, 0, 0, CLI);
      chk("cli_pc", 32'(pc), CMP ? 32'h012 : 32'h014);
      chk("cli_isc", {31'b0, if_id_is_c}, {31'b0, CMP});
      // Interrupt entry at 0x020 and return (with stall)
      step(0, 0, 1, 'h020, 0, 0, ADDI);
      step(0, 0, 0, 0, 1, 0, ADDI);
      chk("int_ack_pulse", {31'b0, ack_seen}, 32'd1);
      chk("int_sel", {31'b0, sel_isr}, 32'd1);
      chk("int_pc", 32'(pc), 32'h0);
      chk("int_valid", {31'b0, if_id_valid}, 32'd0);
      step(0, 0, 0, 0, 1, 0, ADDI);
      chk("isr_noack", {31'b0, ack_seen}, 32'd0);
      chk("isr_pc", 32'(pc), 32'h4);
      step(0, 1, 0, 0, 0, 1, ADDI);
      chk("ret_pc", 32'(pc), 32'h020);
      chk("ret_sel", {31'b0, sel_isr}, 32'd0);
      // Held int_req is retaken; then reset mid-ISR
      step(0, 0, 0, 0, 1, 0, ADDI);
      chk("retake_ack", {31'b0, ack_seen}, 32'd1);
      step(1, 0, 0, 0, 1, 0, ADDI);
      chk("rst_isr_sel", {31'b0, sel_isr}, 32'd0);
      chk("rst_isr_pc", 32'(pc), 32'h0);
      // Redirect overrides stall; then stall freezes everything
      step(0, 1, 1, 'h101, 0, 0, ADDI);
      chk("rs_pc", 32'(pc), 32'h100);
      chk("rs_valid", {31'b0, if_id_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0, 1, 1, $urandom);
         chk("stall_pc", 32'(pc), 32'h100);
         chk("stall_inst", if_id_inst, NOP);
      end
      // Wrap at the top of the address space
      step(0, 0, 1, 'hFFC, 0, 0, ADDI);
      step(0, 0, 0, 0, 0, 0, ADDI);
      chk("wrap_pc", 32'(pc), 32'h0);
`ifdef COMPRESSED_FETCH_EN
      step(0, 0, 1, 'hFFE, 0, 0, ADDI);
      step(0, 0, 0, 0, 0, 0, CLI);
      chk("wrap_c_pc", 32'(pc), 32'h0);
`endif
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         ri = $urandom;
         if ($urandom_range(0, 1) == 1) ri[1:0] = 2'b11;
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 10, $urandom_range(0, 4095),
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15, ri);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter PC_ADDR_BITS, default `PC_ADDR_BITS (12): byte-address width of PC and instruction memory address.
REQ-002 Parameter WORD_WIDTH, default `WORD_WIDTH (32): instruction width.
REQ-003 Parameter NOP_INST, default 32'h00000013: value loaded into if_id_inst on reset or bubble.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stall  input  1  hold PC and IF/ID register.
REQ-007 redirect  input  1  branch/jump taken; load redirect_pc.
REQ-008 redirect_pc  input  PC_ADDR_BITS  target byte address.
REQ-009 int_req  input  1  interrupt request (level).
REQ-010 isr_ret  input  1  return from ISR (one-cycle pulse).
REQ-011 inst  input  WORD_WIDTH  combinational instruction-memory read data for pc.
REQ-012 pc  output  PC_ADDR_BITS  fetch address to instruction memory.
REQ-013 sel_isr  output  1  selects ISR ROM; high while state is ISR.
REQ-014 int_ack  output  1  one-cycle pulse on ISR entry.
REQ-015 if_id_inst / if_id_pc / if_id_valid / if_id_is_c  output  WORD_WIDTH / PC_ADDR_BITS / 1 / 1  IF/ID pipeline register.

Function
REQ-016 Two states: NORM (main ROM) and ISR (ISR ROM); sel_isr = (state == ISR), registered.
REQ-017 Per-edge priority: rst > redirect > int entry > isr_ret > stall > sequential.
REQ-018 Sequential: pc <= pc + 2 if inst[1:0] != 2'b11, else pc + 4; modulo 2^PC_ADDR_BITS (wrap 0xFFE+2 -> 0x000).
REQ-019 Sequential advance: if_id_inst <= inst, if_id_pc <= pc, if_id_valid <= 1, if_id_is_c <= (inst[1:0] != 2'b11).
REQ-020 Latency: instruction at pc appears on if_id_* one edge after a non-stalled cycle.
REQ-021 Stall: pc, state, and all if_id_* hold; no increment.
REQ-022 Redirect: pc <= {redirect_pc[PC_ADDR_BITS-1:1], 1'b0}; if_id_valid <= 0, if_id_inst <= NOP_INST; state unchanged; overrides stall.
REQ-023 Int entry: condition state == NORM && int_req && !stall && !redirect; epc <= pc; pc <= 0; state <= ISR; int_ack = 1 for that cycle only; IF/ID bubbled.
REQ-024 int_req in ISR state is ignored (no nesting); held int_req is re-taken after return.
REQ-025 isr_ret in ISR state: pc <= epc; state <= NORM; IF/ID bubbled; isr_ret in NORM is ignored.
REQ-026 isr_ret with stall: return still taken (overrides stall).
REQ-027 int_ack is combinational from registered state and inputs; never high in ISR state or during rst.

Reset
REQ-028 On rst: pc = 0, state = NORM, sel_isr = 0, epc = 0, if_id_valid = 0, if_id_inst = NOP_INST, if_id_pc = 0, if_id_is_c = 0, int_ack = 0.
REQ-029 rst asserted in ISR state returns to NORM at pc 0; epc discarded.

Configuration
REQ-030 Macro COMPRESSED_FETCH_EN defined: REQ-018/019 as stated; halfword-aligned PC permitted.
REQ-031 Macro COMPRESSED_FETCH_EN undefined: pc always += 4; if_id_is_c = 0; redirect_pc[1:0] forced to 2'b00.

Verification
REQ-032 rst, then inst = 32'h00500093 held for 3 cycles -> pc 0, 4, 8; if_id_pc 0, 4; if_id_valid = 1 from cycle 2.
REQ-033 pc = 0x010 with inst = 16'h4505 (c.li) -> next pc = 0x012, if_id_is_c = 1; with macro undefined -> pc = 0x014, is_c = 0.
REQ-034 pc = 0x020, int_req = 1 -> int_ack pulse, sel_isr = 1, pc = 0, if_id_valid = 0; later isr_ret -> pc = 0x020, sel_isr = 0.
REQ-035 stall = 1 and redirect = 1 with redirect_pc = 0x101 -> pc = 0x100, if_id_valid = 0; stall alone for 4 cycles -> all outputs frozen.
REQ-036 pc = 0xFFC with a 32-bit inst -> pc wraps to 0x000; rst asserted mid-ISR -> sel_isr = 0, pc = 0 next edge.
